periph_bus_master: RTL and testbench
====================================

# periph_bus_master

Initiator side of the MAKu peripheral register bus. It accepts single CPU load/store requests over a valid/ready handshake and decodes the slot number. It drives a one-cycle `reg_en`/`reg_we`/`reg_addr`/`reg_wdata` access to the selected peripheral (GPIO, timers, UART, …), captures that peripheral's registered `reg_rdata`, and returns a response over a second valid/ready handshake. The block sits between the core load/store unit and all memory-mapped peripherals; accesses to unpopulated slots return an error without touching the bus.

## Interface
- `NUM_SLOTS`, 8: number of peripheral slots. Must be a power of two, ≤16.
- `SLOT_MASK`, 8'h01: bit i = 1 marks slot i as populated.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in log2(NUM_SLOTS)+4: upper bits = slot, `[3:0]` = register address.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: read data. 0 for writes and errors.
- `rsp_err` out 1: unpopulated slot accessed.
- `reg_en` out NUM_SLOTS: one-hot slot enable.
- `reg_we` out 1: shared write strobe.
- `reg_addr` out 4: shared register address.
- `reg_wdata` out 32: shared write data.
- `reg_rdata` in NUM_SLOTS*32: packed per-slot read data, slot i at `[32*i+31:32*i]`.

## Operation
- FSM states are IDLE, ACCESS, CAPTURE and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch `we`, slot, `addr[3:0]` and `wdata`.
  - Slot populated → ACCESS.
  - Slot unpopulated → RESP with `rsp_err` = 1, `rsp_rdata` = 0, and no `reg_en` pulse.
- **ACCESS**
  - Exactly one cycle.
  - `reg_en[slot]` = 1; `reg_we`, `reg_addr` and `reg_wdata` are driven from the latched values.
  - Write → RESP. Read → CAPTURE.
- **CAPTURE**
  - `rsp_rdata` ← `reg_rdata` slice of the latched slot.
  - → RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, → IDLE.
- `req_ready` is 0 in every state except IDLE. Request inputs are sampled only at the handshake cycle.
- Outside ACCESS, `reg_en` = 0. `reg_we`, `reg_addr` and `reg_wdata` are driven to 0 outside ACCESS.
- One `reg_en` pulse per accepted request, never repeated. This is mandatory because peripherals have side effects on access (RW1C status clears).
- Only one transaction is outstanding at a time. There is no pipelining.

## Timing
- Request handshake at cycle T:
  - Write: `reg_en` at T+1, `rsp_valid` from T+2.
  - Read: `reg_en` at T+1, peripheral `reg_rdata` valid at T+2, sampled at T+2, `rsp_valid` from T+3.
  - Error: `rsp_valid` from T+1.
- Response handshake at cycle R → `req_ready` = 1 at R+1. Minimum interval between accepted requests: write 3 cycles, read 4, error 2.
- `rsp_valid` stays high with stable data until `rsp_ready`. A response stalled for any number of cycles is allowed.
- Reset values:
  - `req_ready` = 1 (IDLE).
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - `reg_en` = 0, `reg_we` = 0, `reg_addr` = 0, `reg_wdata` = 0.
- Reset asserted mid-transaction: all outputs go immediately (asynchronously) to their reset values. The in-flight request is dropped with no response. An ACCESS cut by reset is not reissued.
- `rsp_ready` high while not in RESP is ignored.

## Structure
- Package `periph_bus_pkg` holds:
  - `REG_ADDR_W` = 4, `DATA_W` = 32.
  - The state enum `pbm_state_e`.
  - Slot index constants (`SLOT_GPIO` = 0, further slots added as peripherals land).
- Sub-module `periph_slot_decode` (combinational):
  - Inputs: slot index, `SLOT_MASK`.
  - Outputs: one-hot enable vector and the populated flag.

## Test plan
- **Write.** With a GPIO model in slot 0, request we=1, addr 0x01, wdata 0x0000_00FF.
  - Exactly one `reg_en[0]` pulse at T+1 with `reg_addr` = 1 and `reg_wdata` = 0xFF.
  - `rsp_valid` at T+2 with `rsp_err` = 0.
- **Read-back.** Request we=0, addr 0x01.
  - `rsp_rdata` = 0x0000_00FF at T+3.
- **Unmapped slot.** Request addr 0x35 (slot 3, unpopulated).
  - `rsp_valid` at T+1 with `rsp_err` = 1 and `rsp_rdata` = 0.
  - `reg_en` stays 0 throughout.
- **Backpressure.**
  - Hold `rsp_ready` = 0 for 10 cycles: `rsp_valid` and `rsp_rdata` stay stable, `req_ready` stays 0, and a second `req_valid` is not accepted.
  - Release `rsp_ready`: `req_ready` = 1 the next cycle.
- **RW1C single pulse.** GPIO status register 0x3 holds 0x0000_0005; write 0x1.
  - Exactly one `reg_en` cycle.
  - Status reads back 0x4.
- **Reset mid-read.** Assert `rst_n` = 0 during CAPTURE.
  - `rsp_valid` never asserts.
  - All outputs return to their reset values immediately.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared constants and types for the MAKu peripheral register bus.
package periph_bus_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    PBM_IDLE    = 2'd0,
    PBM_ACCESS  = 2'd1,
    PBM_CAPTURE = 2'd2,
    PBM_RESP    = 2'd3
  } pbm_state_e;

  // Slot assignments; new peripherals take the next free index.
  localparam int SLOT_GPIO = 0;

endpackage

// File: rtl/periph_slot_decode.sv
// Combinational slot decode: one-hot enable vector plus a populated flag
// derived from the slot mask.
module periph_slot_decode
  import periph_bus_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic [SLOT_W-1:0]    slot,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic [NUM_SLOTS-1:0] slot_onehot,
  output logic                 populated
);

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_onehot
    assign slot_onehot[gi] = (slot == SLOT_W'(gi));
  end

  assign populated = |(slot_onehot & slot_mask);

endmodule

// File: rtl/periph_bus_master.sv
// Initiator for the peripheral register bus: one outstanding CPU request,
// a single-cycle reg_en strobe per access and a held response.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int                   NUM_SLOTS = 8,
  parameter logic [NUM_SLOTS-1:0] SLOT_MASK = 8'h01,
  localparam int                  SLOT_W    = $clog2(NUM_SLOTS),
  localparam int                  ADDR_W    = SLOT_W + REG_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [NUM_SLOTS-1:0]        reg_en,
  output logic                        reg_we,
  output logic [REG_ADDR_W-1:0]       reg_addr,
  output logic [DATA_W-1:0]           reg_wdata,
  input  logic [NUM_SLOTS*DATA_W-1:0] reg_rdata
);

  localparam logic [1:0] ST_IDLE    = PBM_IDLE;
  localparam logic [1:0] ST_ACCESS  = PBM_ACCESS;
  localparam logic [1:0] ST_CAPTURE = PBM_CAPTURE;
  localparam logic [1:0] ST_RESP    = PBM_RESP;

  logic [1:0]            state_reg, state_next;
  logic                  we_reg;
  logic [SLOT_W-1:0]     slot_reg;
  logic [NUM_SLOTS-1:0]  sel_reg;
  logic [REG_ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W-1:0]     rdata_reg;
  logic                  err_reg;

  logic [SLOT_W-1:0]     req_slot;
  logic [NUM_SLOTS-1:0]  req_onehot;
  logic                  req_populated;
  logic                  accept;
  logic                  in_access;

  assign req_slot = req_addr[ADDR_W-1:REG_ADDR_W];

  periph_slot_decode #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_decode (
    .slot        (req_slot),
    .slot_mask   (SLOT_MASK),
    .slot_onehot (req_onehot),
    .populated   (req_populated)
  );

  assign accept    = (state_reg == ST_IDLE) && req_valid;
  assign in_access = (state_reg == ST_ACCESS);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (req_valid) state_next = req_populated ? ST_ACCESS : ST_RESP;
      ST_ACCESS:  state_next = we_reg ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_next = ST_RESP;
      ST_RESP:    if (rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Reset drops any in-flight request; the ACCESS strobe is never replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      slot_reg  <= '0;
      sel_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= req_we;
        slot_reg  <= req_slot;
        sel_reg   <= req_onehot;
        addr_reg  <= req_addr[REG_ADDR_W-1:0];
        wdata_reg <= req_wdata;
        rdata_reg <= '0;
        err_reg   <= ~req_populated;
      end
      if (state_reg == ST_CAPTURE) begin
        rdata_reg <= reg_rdata[int'(slot_reg)*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  // Shared bus lines are only non-zero during the single ACCESS cycle.
  assign reg_en    = in_access ? sel_reg   : '0;
  assign reg_we    = in_access ? we_reg    : 1'b0;
  assign reg_addr  = in_access ? addr_reg  : '0;
  assign reg_wdata = in_access ? wdata_reg : '0;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master with a GPIO register model in slot 0.
module tb_periph_bus_master;

  localparam int NS = 8;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [NS-1:0] reg_en;
  logic          reg_we;
  logic [3:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [NS*32-1:0] reg_rdata;

  int checks = 0;
  int failures = 0;
  int en_count = 0;
  int bad_en_count = 0;

  always #5 clk = ~clk;

  periph_bus_master #(.NUM_SLOTS(NS), .SLOT_MASK(8'h01)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  // GPIO model: register 3 is a RW1C status register preset to 5.
  logic [31:0] gpio_regs [16];
  logic [31:0] gpio_rdata = 32'h0;
  logic        model_loaded = 1'b0;

  always @(posedge clk) begin
    if (!model_loaded) begin
      gpio_regs[3] <= 32'h5;
      model_loaded <= 1'b1;
    end else if (reg_en[0]) begin
      if (reg_we) begin
        if (reg_addr == 4'h3) gpio_regs[3] <= gpio_regs[3] & ~reg_wdata;
        else                  gpio_regs[reg_addr] <= reg_wdata;
      end else begin
        gpio_rdata <= gpio_regs[reg_addr];
      end
    end
  end

  for (genvar gi = 1; gi < NS; gi++) begin : g_other
    assign reg_rdata[32*gi +: 32] = 32'hBAD0_0000 | 32'(gi);
  end
  assign reg_rdata[31:0] = gpio_rdata;

  always @(posedge clk) begin
    if (reg_en != '0) en_count <= en_count + 1;
    if ((reg_en & ~8'h01) != '0) bad_en_count <= bad_en_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    int lat;
    int en_before;
    tick();
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    en_before = en_count;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    check("reg_en_t1", 32'(reg_en), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      check("reg_we_t1", 32'(reg_we), 32'(we));
      check("reg_addr_t1", 32'(reg_addr), 32'(addr[3:0]));
      check("reg_wdata_t1", reg_wdata, wdata);
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("req_ready_after_rsp", 32'(req_ready), 32'd1);
    check("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
    check("reg_en_pulses", 32'(en_count - en_before), exp_err ? 32'd0 : 32'd1);
    $display("txn we=%0d addr=0x%02h wdata=0x%08h -> lat=%0d err=%0d rdata=0x%08h",
             we, addr, wdata, lat, rsp_err, rsp_rdata);
  endtask

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] held_rdata;
    int en_before;

    vecs[0] = '{1'b1, 7'h01, 32'h0000_00FF, 1'b0, 32'h0,          2};
    vecs[1] = '{1'b0, 7'h01, 32'h0,         1'b0, 32'h0000_00FF,  3};
    vecs[2] = '{1'b0, 7'h35, 32'h0,         1'b1, 32'h0,          1};
    vecs[3] = '{1'b1, 7'h02, 32'hDEAD_BEEF, 1'b0, 32'h0,          2};
    vecs[4] = '{1'b0, 7'h02, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF,  3};
    vecs[5] = '{1'b0, 7'h03, 32'h0,         1'b0, 32'h0000_0005,  3};
    vecs[6] = '{1'b1, 7'h03, 32'h0000_0001, 1'b0, 32'h0,          2};
    vecs[7] = '{1'b0, 7'h03, 32'h0,         1'b0, 32'h0000_0004,  3};
    vecs[8] = '{1'b1, 7'h7F, 32'hFFFF_FFFF, 1'b1, 32'h0,          1};
    vecs[9] = '{1'b0, 7'h10, 32'h0,         1'b1, 32'h0,          1};

    // Reset values while held in reset
    repeat (2) tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_reg_en", 32'(reg_en), 32'd0);
    check("rst_reg_bus", {reg_wdata[27:0], reg_addr} | 32'(reg_we), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
             vecs[i].exp_rdata, vecs[i].exp_lat);
    end

    // Backpressure: stalled response with a competing request held high
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h02;
    en_before = en_count;
    tick();
    req_we = 1'b1; req_addr = 7'h01; req_wdata = 32'hAAAA_AAAA;
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    held_rdata = rsp_rdata;
    check("bp_rdata", held_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== held_rdata || req_ready !== 1'b0) begin
        check("bp_hold_valid", 32'(rsp_valid), 32'd1);
        check("bp_hold_rdata", rsp_rdata, held_rdata);
        check("bp_hold_req_ready", 32'(req_ready), 32'd0);
      end
    end
    check("bp_end_valid", 32'(rsp_valid), 32'd1);
    check("bp_end_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("bp_end_req_ready", 32'(req_ready), 32'd0);
    check("bp_no_second_accept", 32'(en_count - en_before), 32'd1);
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_req_ready_after", 32'(req_ready), 32'd1);
    $display("txn backpressure read 0x02 held 10 cycles rdata=0x%08h", held_rdata);

    // Reset asserted while in CAPTURE
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h01; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rr_access_en", 32'(reg_en), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rr_req_ready", 32'(req_ready), 32'd1);
    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rr_rsp_rdata", rsp_rdata, 32'd0);
    check("rr_rsp_err", 32'(rsp_err), 32'd0);
    check("rr_reg_en", 32'(reg_en), 32'd0);
    en_before = en_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) rst_n = 1'b1;
      if (rsp_valid) check("rr_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;
    check("rr_no_reissue", 32'(en_count - en_before), 32'd0);
    check("rr_rsp_valid_after", 32'(rsp_valid), 32'd0);
    $display("txn reset during capture, request dropped");
    do_req(1'b0, 7'h01, 32'h0, 1'b0, 32'h0000_00FF, 3);

    check("no_unpopulated_en", 32'(bad_en_count), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
